spi_ram_slave_param: RTL
========================

SPI_RAM_SLAVE_PARAM -- requirements
Module: spi_ram_slave_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of address payload and address registers.
REQ-002 Parameter DATA_WIDTH, default 8, width of memory word and data payload.
REQ-003 Parameter MEM_DEPTH, default 256, number of words; SHALL be <= 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all sampling on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SS_n  input  1  slave select, active-low; high frames off any transfer.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, registered, MSB first.

Function
REQ-009 Frame: SS_n low, 2-bit opcode, then payload; opcodes 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-010 FSM states IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE; IDLE->CMD on edge with SS_n low, sampling opcode bit 1 at that edge.
REQ-011 CMD samples opcode bit 0 on next edge, then enters the opcode's payload state.
REQ-012 WR_ADDR/RD_ADDR shift in ADDR_WIDTH bits; on last bit's edge load wr_addr/rd_addr; RD_ADDR also sets rd_valid.
REQ-013 WR_DATA shifts DATA_WIDTH bits; mem[wr_addr] written on the edge sampling the last bit.
REQ-014 RD_DATA: edge after opcode loads mem[rd_addr] into shift register, MISO = MSB; each following edge presents next bit; DATA_WIDTH bits total; MOSI ignored.
REQ-015 RD_DATA with rd_valid=0 SHALL output all-zero bits and not change rd_addr.
REQ-016 Address >= MEM_DEPTH: write-data SHALL not modify memory; read-data SHALL output zeros.
REQ-017 After payload completes, FSM enters DONE; MISO=0 and MOSI ignored until SS_n high.
REQ-018 SS_n high on any edge SHALL return FSM to IDLE at that edge; partial frame discarded, no memory write, no address update.
REQ-019 MISO SHALL be 0 in every state except RD_DATA.
REQ-020 wr_addr, rd_addr, rd_valid persist across frames.

Reset
REQ-021 rst_n low SHALL immediately force FSM IDLE, MISO 0, wr_addr 0, rd_addr 0, rd_valid 0, shift registers 0.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 Reset mid-frame aborts the frame; no write occurs even if last bit coincides with reset assertion.

Configuration
REQ-024 Macro SPI_RAM_AUTO_INC_EN defined: after each completed write-data frame wr_addr increments, after each completed read-data frame with rd_valid=1 rd_addr increments; MEM_DEPTH-1 wraps to 0.
REQ-025 SPI_RAM_AUTO_INC_EN undefined: addresses change only via address frames; no increment logic synthesised.

Verification
REQ-026 Reset low, random MOSI/SS_n 5 cycles -> MISO 0, preloaded memory unchanged.
REQ-027 Frames 00+0x3C, 01+0xA5, 10+0x3C, 11 -> MISO serialises 1,0,1,0,0,1,0,1 on the 8 edges after opcode.
REQ-028 Reset, then 11 frame without read-address -> MISO 0 for 8 bits; memory unchanged.
REQ-029 01 frame with SS_n raised after 5 payload bits -> mem[wr_addr] unchanged, next frame decodes normally from IDLE.
REQ-030 With SPI_RAM_AUTO_INC_EN, 00+0xFF, 01+0x11, 01+0x22 -> mem[255]=0x11, mem[0]=0x22; without macro -> mem[255]=0x22.
REQ-031 MEM_DEPTH=200: 00+0xC8, 01+0x77 -> no memory change; 10+0xC8, 11 -> MISO all zeros.

Source files
------------

// File: rtl/spi_ram_slave_param.sv
// -----------------------------------------------------------------------------
// spi_ram_slave_param
//   SPI-style slave giving serial access to a small single-port RAM.
//   Each frame (SS_n low) starts with a 2-bit opcode, MSB first:
//     00 write-address, 01 write-data, 10 read-address, 11 read-data,
//   followed by the payload. Addresses persist across frames.
//
//   Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr
//   after every completed write-data frame and rd_addr after every completed
//   valid read-data frame (MEM_DEPTH-1 wraps to 0).
//
// Parameters
//   ADDR_WIDTH : address payload / address register width (>= 2)
//   DATA_WIDTH : memory word / data payload width (>= 2)
//   MEM_DEPTH  : number of words, <= 2**ADDR_WIDTH
//
// Ports
//   clk   : clock, all sampling on the rising edge
//   rst_n : asynchronous active-low reset (memory contents are kept)
//   SS_n  : slave select, active-low; high aborts any frame
//   MOSI  : serial data in, MSB first
//   MISO  : registered serial data out, MSB first; 0 outside read-data
// -----------------------------------------------------------------------------
module spi_ram_slave_param #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   typedef enum logic [2:0] {
      IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE
   } state_t;

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);

   localparam logic [ADDR_WIDTH:0] DEPTH     = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0]    DATA_END  = CNT_W'(DATA_WIDTH);

   state_t                  state;
   logic                    op_hi;
   logic [CNT_W-1:0]        bit_cnt;
   logic [ADDR_WIDTH-2:0]   addr_sh;   // address bits received so far
   logic [DATA_WIDTH-1:0]   data_sh;   // write shift-in / read shift-out
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    rd_valid;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   // Value each shift register holds once the bit on MOSI is taken in.
   logic [ADDR_WIDTH-1:0] addr_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  mem_we;

   assign addr_in     = {addr_sh, MOSI};
   assign data_in     = {data_sh[DATA_WIDTH-2:0], MOSI};
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
   // Never-loaded or out-of-range read address reads as all zeros.
   assign rd_word     = (rd_valid && rd_in_range) ? mem[rd_addr] : '0;

   // rst_n in the enable blocks a write whose last bit lands on the same edge
   // reset is asserted, since the memory itself is not in the reset domain.
   assign mem_we = rst_n && !SS_n && (state == WR_DATA) &&
                   (bit_cnt == DATA_LAST) && wr_in_range;

`ifdef SPI_RAM_AUTO_INC_EN
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} == DEPTH - 1'b1) ? '0 : a + 1'b1;
   endfunction
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_hi    <= 1'b0;
         bit_cnt  <= '0;
         addr_sh  <= '0;
         data_sh  <= '0;
         wr_addr  <= '0;
         rd_addr  <= '0;
         rd_valid <= 1'b0;
         MISO     <= 1'b0;
      end else if (SS_n) begin
         // Deselect discards any partial frame.
         state   <= IDLE;
         bit_cnt <= '0;
         addr_sh <= '0;
         data_sh <= '0;
         MISO    <= 1'b0;
      end else begin
         MISO <= 1'b0;
         case (state)
            IDLE: begin
               op_hi   <= MOSI;
               bit_cnt <= '0;
               state   <= CMD;
            end
            CMD: begin
               bit_cnt <= '0;
               case ({op_hi, MOSI})
                  2'b00:   state <= WR_ADDR;
                  2'b01:   state <= WR_DATA;
                  2'b10:   state <= RD_ADDR;
                  default: state <= RD_DATA;
               endcase
            end
            WR_ADDR, RD_ADDR: begin
               addr_sh <= addr_in[ADDR_WIDTH-2:0];
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == ADDR_LAST) begin
                  state <= DONE;
                  if (state == WR_ADDR) begin
                     wr_addr <= addr_in;
                  end else begin
                     rd_addr  <= addr_in;
                     rd_valid <= 1'b1;
                  end
               end
            end
            WR_DATA: begin
               data_sh <= data_in;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == DATA_LAST) begin
                  state <= DONE;
`ifdef SPI_RAM_AUTO_INC_EN
                  wr_addr <= next_addr(wr_addr);
`endif
               end
            end
            RD_DATA: begin
               // First edge loads the word and presents its MSB; the next
               // DATA_WIDTH-1 edges shift out the rest; one more edge ends.
               if (bit_cnt == '0) begin
                  MISO    <= rd_word[DATA_WIDTH-1];
                  data_sh <= {rd_word[DATA_WIDTH-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (bit_cnt < DATA_END) begin
                  {MISO, data_sh} <= {data_sh, 1'b0};
                  bit_cnt         <= bit_cnt + 1'b1;
               end else begin
                  state <= DONE;
`ifdef SPI_RAM_AUTO_INC_EN
                  if (rd_valid) rd_addr <= next_addr(rd_addr);
`endif
               end
            end
            DONE:    state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the RAM array is deliberately left out of reset so its contents
   // survive rst_n; it is written only through mem_we.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr] <= data_in;
   end

endmodule
